minterm_checker: RTL and testbench

Sequential truth-table checker for the two-input gate-level function blocks in the exercise set. It drives every minterm of the input space onto the device under test in ascending order, waits a settle interval, and samples the single response bit. It compares each sample against a parameterised expected truth-table vector and reports an error count, a per-minterm failure mask and pass/fail. It sits opposite the gate-level combinational block: it generates the stimulus and checks the response.

---
 rtl/minterm_checker.sv | 155 +++++++++++++++
 tb/tb_minterm_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/minterm_checker.sv
// minterm_checker: sequential truth-table checker for small combinational blocks.
// It sweeps every minterm of the N_IN-input space onto drv in ascending order.
// For each minterm it waits SETTLE+1 cycles, then samples resp once and compares
// it against the matching bit of EXPECT. Results are an error count, a
// per-minterm failure mask, and done/pass flags.
// Optional feature: define MINTERM_CHECKER_STOP_ON_FAIL_EN to end the sweep at
// the first mismatching minterm.
module minterm_checker #(
    parameter int                     N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b1101,
    parameter int                     SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_IN-1:0]           drv,
    input  logic                      resp,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [N_IN-1:0]           idx,
    output logic [N_IN:0]             err_cnt,
    output logic [(2**N_IN)-1:0]      fail_mask
);

    localparam int M = 2**N_IN;

    // SETTLE is limited to 0..15, so a 4-bit counter holds the reload value.
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(M - 1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN:0]     err_q, err_d;
    logic [M-1:0]      mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mism_s;

    // Returns 1 when the sampled response differs from the expected truth-table bit.
    function automatic logic resp_mismatch(input logic [N_IN-1:0] k, input logic r);
        return (r != EXPECT[k]);
    endfunction

    // Next-state logic: sweep sequencing, counters and result accumulation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        mask_d  = mask_q;
        mism_s  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = {N_IN{1'b0}};
                    err_d   = {(N_IN + 1){1'b0}};
                    mask_d  = {M{1'b0}};
                    cnt_d   = SETTLE_LD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                mism_s = resp_mismatch(idx_q, resp);
                if (mism_s) begin
                    err_d         = err_q + ERR_ONE;
                    mask_d[idx_q] = 1'b1;
                end else begin
                    err_d = err_q;
                end
`ifdef MINTERM_CHECKER_STOP_ON_FAIL_EN
                // A mismatch ends the sweep with idx left on the failing minterm.
                if (mism_s || (idx_q == IDX_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_WAIT;
                end
`else
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_WAIT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are computed from the next state so that they register with it.
    always_comb begin
        busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == {(N_IN + 1){1'b0}});
    end

    // State and output registers; asynchronous reset clears everything to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= {N_IN{1'b0}};
            err_q   <= {(N_IN + 1){1'b0}};
            mask_q  <= {M{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // drv and idx come from the same register, so they always agree.
    assign drv       = idx_q;
    assign idx       = idx_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_minterm_checker.sv
// Self-checking bench for minterm_checker (default parameters).
// resp is produced by a lookup table indexed by drv, which emulates the block
// under test. Expected results come from fixed vectors and from a reference
// model that works directly on the truth table.
module tb_minterm_checker;

    localparam int         M      = 4;
    localparam logic [3:0] EXPECT = 4'b1101;
    localparam int         SETTLE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] drv;
    logic       resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] idx;
    logic [2:0] err_cnt;
    logic [3:0] fail_mask;
    logic [3:0] resp_tbl;

    int checks = 0;
    int errors = 0;

    minterm_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .drv       (drv),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .idx       (idx),
        .err_cnt   (err_cnt),
        .fail_mask (fail_mask)
    );

    assign resp = resp_tbl[drv];

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] tbl;
        logic [3:0] e_mask;
        int         e_err;
        int         e_idx;
        int         e_cyc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: mismatches are the XOR of the response table and EXPECT.
    function automatic void model(input logic [3:0] tbl, output logic [3:0] mask,
                                  output int e_err, output int e_idx, output int e_cyc);
        logic [3:0] mm;
        mm    = tbl ^ EXPECT;
        mask  = 4'b0000;
        e_idx = M - 1;
`ifdef MINTERM_CHECKER_STOP_ON_FAIL_EN
        for (int k = M - 1; k >= 0; k--) begin
            if (mm[k]) begin
                e_idx = k;
            end
        end
        if (mm != 4'b0000) begin
            mask[e_idx] = 1'b1;
        end
`else
        mask = mm;
`endif
        e_err = $countones(mask);
        e_cyc = (e_idx + 1) * (SETTLE + 2);
    endfunction

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_pass"}, pass, 0);
        chk({nm, "_idx"}, idx, 0);
        chk({nm, "_drv"}, drv, 0);
        chk({nm, "_err"}, err_cnt, 0);
        chk({nm, "_mask"}, fail_mask, 0);
    endtask

    // Starts a sweep and follows it to done; restart_at > 0 pulses start on that edge.
    task automatic run(input string nm, input logic [3:0] tbl, input logic [3:0] e_mask,
                       input int e_err, input int e_idx, input int e_cyc, input int restart_at);
        int n;
        resp_tbl = tbl;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, "_busy_e0"}, busy, 1);
        chk({nm, "_done_e0"}, done, 0);
        chk({nm, "_pass_e0"}, pass, 0);
        chk({nm, "_idx_e0"}, idx, 0);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (drv !== idx) begin
                chk({nm, "_drv_eq_idx"}, drv, idx);
            end
            if (done !== 1'b1) begin
                chk({nm, "_busy_mid"}, busy, 1);
            end
            start = (n + 1 == restart_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk({nm, "_done_edge"}, n, e_cyc);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_err"}, err_cnt, e_err);
        chk({nm, "_mask"}, fail_mask, e_mask);
        chk({nm, "_pass"}, pass, (e_err == 0) ? 1 : 0);
        chk({nm, "_idx"}, idx, e_idx);
        chk({nm, "_drv"}, drv, e_idx);
    endtask

    initial begin
        vec_t       vecs[4];
        logic [3:0] m_mask;
        logic [3:0] rt;
        int         m_err;
        int         m_idx;
        int         m_cyc;

`ifdef MINTERM_CHECKER_STOP_ON_FAIL_EN
        vecs[0] = '{"correct",  4'b1101, 4'b0000, 0, 3, 12};
        vecs[1] = '{"stuck0",   4'b0000, 4'b0001, 1, 0, 3};
        vecs[2] = '{"inverted", 4'b0010, 4'b0001, 1, 0, 3};
        vecs[3] = '{"stuck1",   4'b1111, 4'b0010, 1, 1, 6};
`else
        vecs[0] = '{"correct",  4'b1101, 4'b0000, 0, 3, 12};
        vecs[1] = '{"stuck0",   4'b0000, 4'b1101, 3, 3, 12};
        vecs[2] = '{"inverted", 4'b0010, 4'b1111, 4, 3, 12};
        vecs[3] = '{"stuck1",   4'b1111, 4'b0010, 1, 3, 12};
`endif

        rst_n    = 1'b0;
        start    = 1'b0;
        resp_tbl = 4'b0000;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("idle");

        // Fixed truth-table vectors, each started from IDLE or DONE.
        for (int i = 0; i < 4; i++) begin
            run(vecs[i].name, vecs[i].tbl, vecs[i].e_mask, vecs[i].e_err,
                vecs[i].e_idx, vecs[i].e_cyc, 0);
        end

        // A start pulse mid-sweep is ignored; the restart from DONE reruns identically.
        run("restart_busy", 4'b0000, vecs[1].e_mask, vecs[1].e_err, vecs[1].e_idx,
            (vecs[1].e_cyc > 5) ? vecs[1].e_cyc : vecs[1].e_cyc, 5);
        run("rerun", 4'b0000, vecs[1].e_mask, vecs[1].e_err, vecs[1].e_idx, vecs[1].e_cyc, 0);

        // Asynchronous reset mid-sweep, then a clean sweep.
        resp_tbl = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_rst_idle");
        run("clean_after_rst", 4'b1101, 4'b0000, 0, 3, 12, 0);

        // Random response tables checked against the reference model.
        for (int r = 0; r < 10; r++) begin
            rt = 4'($urandom_range(0, 15));
            model(rt, m_mask, m_err, m_idx, m_cyc);
            run("random", rt, m_mask, m_err, m_idx, m_cyc, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
